m_uart_tx: RTL and testbench
============================

M_UART_TX -- requirements
Module: m_uart_tx

Interface
REQ-001 SHALL have parameter UART_BPS_RATE, default 115200, line baud rate in bit/s.
REQ-002 SHALL have parameter CLK_PERIORD, default 5, i_clk_p period in ns (integer).
REQ-003 SHALL have localparam BIT_CYCLES = (1_000_000_000/UART_BPS_RATE)/CLK_PERIORD, integer division; 1736 at defaults.
REQ-004 SHALL have port i_clk_p, input, 1, clock; all state on rising edge.
REQ-005 SHALL have port i_rst_n, input, 1, reset; asynchronous, active-high.
REQ-006 SHALL have port i_tx_en, input, 1, write strobe; one byte per high cycle.
REQ-007 SHALL have port i_tx_data, input, 8, byte to send; sampled when i_tx_en=1.
REQ-008 SHALL have port o_tx_ready, output, 1, high when the FIFO can accept a write.
REQ-009 SHALL have port o_uart_tx, output, 1, serial line; idle high.
REQ-010 SHALL have port o_tx_busy, output, 1, high while a frame is in progress (state != IDLE).
REQ-011 SHALL have port o_tx_done, output, 1, one-cycle pulse at the end of each frame.
REQ-012 SHALL have port o_fifo_cnt, output, 3, bytes held in the FIFO (0..4).

Function
REQ-013 SHALL send 8N1 frames: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); every bit held exactly BIT_CYCLES clocks.
REQ-014 SHALL buffer writes in a 4-entry FIFO with 2-bit wrapping read/write pointers and a 3-bit count.
REQ-015 SHALL drive o_tx_ready = (o_fifo_cnt < 4), combinational from registered count only; it does not depend on a same-cycle pop.
REQ-016 SHALL accept a write only on an edge where i_tx_en=1 and o_tx_ready=1; a write while full is dropped silently, with no state change.
REQ-017 SHALL update count correctly on a simultaneous accepted write and pop (count unchanged, both pointers advance).
REQ-018 SHALL use FSM states IDLE, START, DATA, STOP, with a bit-cycle counter 0..BIT_CYCLES-1 and a 3-bit data-bit index.
REQ-019 IDLE: o_uart_tx=1; if FIFO non-empty, pop the head into an 8-bit shift register and go to START.
REQ-020 START: o_uart_tx=0 for BIT_CYCLES clocks, then go to DATA with index 0.
REQ-021 DATA: o_uart_tx=shift[0]; after BIT_CYCLES clocks, shift right and advance the index; after index 7 completes, go to STOP.
REQ-022 STOP: o_uart_tx=1 for BIT_CYCLES clocks; on the last cycle pulse o_tx_done. Then, if the FIFO is non-empty, pop and go directly to START (no idle gap); else go to IDLE.
REQ-023 SHALL register o_uart_tx (no combinational path from FSM inputs to the line).
REQ-024 Latency: a write accepted at edge N with the FIFO empty and the FSM in IDLE drives o_uart_tx low after edge N+2.
REQ-025 Frame length: exactly 10*BIT_CYCLES clocks from the start-bit falling edge to the end of the stop bit; back-to-back frames are contiguous.
REQ-026 SHALL ignore i_tx_data when i_tx_en=0; the shift register is loaded only on a pop.

Reset
REQ-027 While i_rst_n=1 (asynchronous): state=IDLE, o_uart_tx=1, o_tx_busy=0, o_tx_done=0, o_fifo_cnt=0, pointers/counters/shift register=0, o_tx_ready=1.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately, force the line high, and discard all FIFO contents; after release, the block idles until a new write.

Verification
REQ-029 Single byte 0xAA at defaults -> line low 1736 clocks, then bits 0,1,0,1,0,1,0,1 each 1736 clocks, then high; o_tx_done pulses once at clock 17360 of the frame.
REQ-030 Loopback into m_s2p/m_bps (same parameters), write 0xAA,0x55,0xA5,0x5A -> receiver reports the same four bytes in order; no frame errors.
REQ-031 Five writes on consecutive cycles while IDLE -> first byte popped and starts transmitting; bytes 2-5 fill the FIFO (cnt=4, o_tx_ready=0); a sixth write is dropped; exactly five frames are sent.
REQ-032 Back-to-back: 0x00 then 0xFF queued -> stop bit of frame 1 is followed immediately by the start bit of frame 2; total 20*1736 clocks of activity.
REQ-033 Reset pulse 3000 clocks into a frame of 0x0F with 2 bytes queued -> o_uart_tx=1 and cnt=0 within the reset; no further frames until a new write.
REQ-034 FIFO full (cnt=4), pop and write on the same edge -> write dropped (o_tx_ready=0 at that edge), cnt becomes 3.

Source files
------------

// File: rtl/m_uart_tx.sv
// UART 8N1 transmitter with a 4-entry write FIFO.
// The line output is registered from the FSM state, so it trails the state by one clock.
module m_uart_tx #(
    parameter int UART_BPS_RATE = 115200,
    parameter int CLK_PERIORD   = 5
) (
    input  logic       i_clk_p,
    input  logic       i_rst_n,
    input  logic       i_tx_en,
    input  logic [7:0] i_tx_data,
    output logic       o_tx_ready,
    output logic       o_uart_tx,
    output logic       o_tx_busy,
    output logic       o_tx_done,
    output logic [2:0] o_fifo_cnt
);

    localparam int BIT_CYCLES = (1_000_000_000 / UART_BPS_RATE) / CLK_PERIORD;
    localparam int CNT_W      = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} t_state;

    t_state           r_state;
    logic [7:0]       r_fifo [4];
    logic [1:0]       r_wptr;
    logic [1:0]       r_rptr;
    logic [2:0]       r_cnt;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_uart_tx;
    logic             r_tx_done;

    logic             w_wr;
    logic             w_pop;
    logic             w_bit_end;

    assign o_tx_ready = (r_cnt < 3'd4);
    assign w_wr       = i_tx_en && o_tx_ready;
    assign w_bit_end  = (r_bit_cnt == BIT_LAST);
    // A pop happens from IDLE, or on the last stop-bit cycle to chain frames without a gap.
    assign w_pop      = (r_cnt != 3'd0) &&
                        ((r_state == IDLE) || ((r_state == STOP) && w_bit_end));

    assign o_uart_tx  = r_uart_tx;
    assign o_tx_done  = r_tx_done;
    assign o_tx_busy  = (r_state != IDLE);
    assign o_fifo_cnt = r_cnt;

    always_ff @(posedge i_clk_p) begin
        if (w_wr) begin
            r_fifo[r_wptr] <= i_tx_data;
        end
    end

    always_ff @(posedge i_clk_p or posedge i_rst_n) begin
        if (i_rst_n) begin
            r_wptr <= 2'd0;
            r_rptr <= 2'd0;
            r_cnt  <= 3'd0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 2'd1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 2'd1;
            end
            case ({w_wr, w_pop})
                2'b10:   r_cnt <= r_cnt + 3'd1;
                2'b01:   r_cnt <= r_cnt - 3'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge i_clk_p or posedge i_rst_n) begin
        if (i_rst_n) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'd0;
            r_uart_tx <= 1'b1;
            r_tx_done <= 1'b0;
        end else begin
            r_tx_done <= (r_state == STOP) && w_bit_end;
            case (r_state)
                START:   r_uart_tx <= 1'b0;
                DATA:    r_uart_tx <= r_shift[0];
                default: r_uart_tx <= 1'b1;
            endcase

            case (r_state)
                IDLE: begin
                    r_bit_cnt <= '0;
                    r_bit_idx <= 3'd0;
                    if (w_pop) begin
                        r_shift <= r_fifo[r_rptr];
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_bit_cnt <= '0;
                        r_bit_idx <= 3'd0;
                        r_state   <= DATA;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_bit_cnt <= '0;
                        r_shift   <= {1'b0, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= STOP;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        r_bit_cnt <= '0;
                        if (w_pop) begin
                            r_shift <= r_fifo[r_rptr];
                            r_state <= START;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_m_uart_tx.sv
// Self-checking bench for m_uart_tx: a line decoder feeds a byte scoreboard.
// Baud parameters are chosen so that one bit lasts 16 clocks, keeping the runs short.
`timescale 1ns/1ps
module tb_m_uart_tx;

    localparam int RATE  = 12_500_000;
    localparam int PER   = 5;
    localparam int BIT   = 16;
    localparam int FRAME = 10 * BIT;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [7:0] data = 8'd0;
    logic       tx_ready, uart_tx, tx_busy, tx_done;
    logic [2:0] fifo_cnt;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    int   cyc = 0;
    bit   in_frame = 1'b0;
    int   k = 0;
    logic [9:0] bits;
    bit   bad;
    int   done_cnt, done_k;
    int   frames = 0;
    int   last_end = -1000, cur_start = 0, prev_start = 0, gap = 0, pair_span = 0;
    int   f0;

    m_uart_tx #(.UART_BPS_RATE(RATE), .CLK_PERIORD(PER)) dut (
        .i_clk_p    (clk),
        .i_rst_n    (rst),
        .i_tx_en    (en),
        .i_tx_data  (data),
        .o_tx_ready (tx_ready),
        .o_uart_tx  (uart_tx),
        .o_tx_busy  (tx_busy),
        .o_tx_done  (tx_done),
        .o_fifo_cnt (fifo_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Line decoder: every bit must stay constant for BIT samples.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            in_frame = 1'b0;
        end else begin
            if (tx_done && !in_frame) chk_eq("done_outside_frame", 1, 0);
            if (!in_frame && uart_tx == 1'b0) begin
                in_frame   = 1'b1;
                k          = 0;
                bad        = 1'b0;
                done_cnt   = 0;
                done_k     = -1;
                gap        = cyc - last_end;
                prev_start = cur_start;
                cur_start  = cyc;
            end
            if (in_frame) begin
                if (k % BIT == 0) bits[k / BIT] = uart_tx;
                else if (uart_tx !== bits[k / BIT]) bad = 1'b1;
                if (tx_done) begin
                    done_cnt++;
                    done_k = k;
                end
                if (k == FRAME - 1) begin
                    chk_eq("start_bit", bits[0], 0);
                    chk_eq("stop_bit", bits[9], 1);
                    chk_eq("bit_stable", bad, 0);
                    chk_eq("done_count", done_cnt, 1);
                    chk_eq("done_pos", done_k, FRAME - 1);
                    if (exp_q.size() == 0) chk_eq("unexpected_frame", 1, 0);
                    else chk_eq("rx_byte", bits[8:1], exp_q.pop_front());
                    $display("frame %0d: byte %02h at cycle %0d", frames, bits[8:1], cyc);
                    frames++;
                    last_end  = cyc;
                    pair_span = cyc - prev_start + 1;
                    in_frame  = 1'b0;
                end else begin
                    k++;
                end
            end
        end
    end

    task automatic wr(input logic [7:0] d, input bit accept);
        @(negedge clk);
        en   = 1'b1;
        data = d;
        #1 chk_eq("ready_at_write", tx_ready, accept);
        if (accept) exp_q.push_back(d);
        @(posedge clk);
        #1;
        en   = 1'b0;
        data = 8'($urandom);
        $display("write %02h accept=%0d cnt=%0d", d, accept, fifo_cnt);
    endtask

    task automatic wait_idle(input int maxc);
        int n = 0;
        while ((exp_q.size() != 0 || in_frame || tx_busy) && n < maxc) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (exp_q.size() != 0 || in_frame || tx_busy) chk_eq("drain_timeout", 1, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_eq("rst_line", uart_tx, 1);
        chk_eq("rst_busy", tx_busy, 0);
        chk_eq("rst_done", tx_done, 0);
        chk_eq("rst_cnt", fifo_cnt, 0);
        chk_eq("rst_ready", tx_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Latency from an accepted write to the start bit
        @(negedge clk);
        en = 1'b1;
        data = 8'hAA;
        exp_q.push_back(8'hAA);
        @(posedge clk);
        #1;
        en = 1'b0;
        data = 8'h3C;
        chk_eq("lat_n_cnt", fifo_cnt, 1);
        chk_eq("lat_n_line", uart_tx, 1);
        chk_eq("lat_n_busy", tx_busy, 0);
        @(posedge clk);
        #1;
        chk_eq("lat_n1_cnt", fifo_cnt, 0);
        chk_eq("lat_n1_busy", tx_busy, 1);
        chk_eq("lat_n1_line", uart_tx, 1);
        @(posedge clk);
        #1;
        chk_eq("lat_n2_line", uart_tx, 0);
        wait_idle(FRAME + 20);

        // Four mixed patterns queued together
        wr(8'hAA, 1); wr(8'h55, 1); wr(8'hA5, 1); wr(8'h5A, 1);
        wait_idle(5 * FRAME);

        // Fill the FIFO, overflow, then write on the same edge as a pop while full
        f0 = frames;
        wr(8'h11, 1); wr(8'h22, 1); wr(8'h33, 1); wr(8'h44, 1); wr(8'h55, 1);
        chk_eq("full_cnt", fifo_cnt, 4);
        chk_eq("full_ready", tx_ready, 0);
        wr(8'h66, 0);
        chk_eq("drop_cnt", fifo_cnt, 4);
        repeat (FRAME - 5) @(posedge clk);
        wr(8'h77, 0);
        chk_eq("pop_write_cnt", fifo_cnt, 3);
        wait_idle(6 * FRAME);
        chk_eq("five_frames", frames - f0, 5);

        // Back-to-back frames with no idle gap
        wr(8'h00, 1); wr(8'hFF, 1);
        wait_idle(3 * FRAME);
        chk_eq("b2b_gap", gap, 1);
        chk_eq("b2b_span", pair_span, 2 * FRAME);

        // Reset mid-frame with bytes still queued
        f0 = frames;
        wr(8'h0F, 1); wr(8'hC3, 1); wr(8'h96, 1);
        chk_eq("pre_rst_cnt", fifo_cnt, 2);
        repeat (40) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk_eq("mid_rst_line", uart_tx, 1);
        chk_eq("mid_rst_cnt", fifo_cnt, 0);
        chk_eq("mid_rst_busy", tx_busy, 0);
        chk_eq("mid_rst_ready", tx_ready, 1);
        exp_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3 * FRAME) @(posedge clk);
        #1;
        chk_eq("post_rst_frames", frames - f0, 0);
        chk_eq("post_rst_line", uart_tx, 1);
        chk_eq("post_rst_busy", tx_busy, 0);
        wr(8'h5A, 1);
        wait_idle(2 * FRAME);
        chk_eq("post_rst_new_frame", frames - f0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
